// File: rtl/conv_serial_scheduler.sv
// Round-robin scheduler framing requester words onto one 2:1 serializer lane.
// Optional PARITY pair after DATA when CONV_SER_PARITY_EN is defined.
module conv_serial_scheduler #(
    parameter int NREQ       = 4,
    parameter int WIDTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NREQ-1:0]       REQ_VALID,
    input  logic [NREQ*WIDTH-1:0] REQ_DATA,
    output logic [NREQ-1:0]       REQ_READY,
    output logic                  PAR_IN1,
    output logic                  PAR_IN2,
    output logic                  SER_EN,
    output logic [1:0]            GRANT_ID,
    output logic                  BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ID,
        S_DATA,
        S_PARITY,
        S_GAP
    } state_t;

    localparam int HALF = WIDTH / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] PAIR_LOAD = CW'(HALF - 1);
    localparam logic [3:0] GAP_LOAD =
        (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_pcnt;
    logic [3:0]       r_gcnt;
    logic             r_par1;
    logic             r_par2;
    logic             r_ser_en;
    logic [1:0]       r_gid;
`ifdef CONV_SER_PARITY_EN
    logic             r_parity;
`endif

    state_t           w_next;
    logic [1:0]       w_ptr;
    logic [WIDTH-1:0] w_sh;
    logic [CW-1:0]    w_pcnt;
    logic [3:0]       w_gcnt;
    logic             w_par1;
    logic             w_par2;
    logic             w_ser_en;
    logic [1:0]       w_gid;
    logic             w_found;
    logic [1:0]       w_gidx;
    logic [1:0]       w_cand;
    logic             w_grant;
    logic [WIDTH-1:0] w_sel_data;

    // First valid requester at or after the round-robin pointer
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = 2'((int'(r_ptr) + k) % NREQ);
            if (!w_found && REQ_VALID[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    assign w_grant    = RESET && (r_state == S_IDLE) && w_found;
    assign w_sel_data = REQ_DATA[w_gidx*WIDTH +: WIDTH];
    assign REQ_READY  = w_grant ? (NREQ'(1) << w_gidx) : '0;

    always_comb begin
        w_next   = r_state;
        w_ptr    = r_ptr;
        w_sh     = r_sh;
        w_pcnt   = r_pcnt;
        w_gcnt   = r_gcnt;
        w_par1   = 1'b0;
        w_par2   = 1'b0;
        w_ser_en = 1'b0;
        w_gid    = r_gid;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next   = S_START;
                    w_par1   = 1'b1;
                    w_ser_en = 1'b1;
                    w_sh     = w_sel_data;
                    w_gid    = w_gidx;
                    w_ptr    = 2'((int'(w_gidx) + 1) % NREQ);
                end
            end
            S_START: begin
                w_next   = S_ID;
                w_par1   = r_gid[1];
                w_par2   = r_gid[0];
                w_ser_en = 1'b1;
            end
            S_ID: begin
                w_next   = S_DATA;
                w_par1   = r_sh[WIDTH-1];
                w_par2   = r_sh[WIDTH-2];
                w_sh     = r_sh << 2;
                w_pcnt   = PAIR_LOAD;
                w_ser_en = 1'b1;
            end
            S_DATA: begin
                if (r_pcnt != '0) begin
                    w_par1   = r_sh[WIDTH-1];
                    w_par2   = r_sh[WIDTH-2];
                    w_sh     = r_sh << 2;
                    w_pcnt   = r_pcnt - 1'b1;
                    w_ser_en = 1'b1;
`ifdef CONV_SER_PARITY_EN
                end else begin
                    w_next   = S_PARITY;
                    w_par1   = r_parity;
                    w_par2   = ~r_parity;
                    w_ser_en = 1'b1;
                end
            end
            S_PARITY: begin
`else
                end else begin
`endif
                if (GAP_CYCLES > 0) begin
                    w_next = S_GAP;
                    w_gcnt = GAP_LOAD;
                end else begin
                    w_next = S_IDLE;
                end
`ifndef CONV_SER_PARITY_EN
                end
`endif
            end
            S_GAP: begin
                if (r_gcnt == 4'd0) begin
                    w_next = S_IDLE;
                end else begin
                    w_gcnt = r_gcnt - 4'd1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_sh     <= '0;
            r_pcnt   <= '0;
            r_gcnt   <= '0;
            r_par1   <= 1'b0;
            r_par2   <= 1'b0;
            r_ser_en <= 1'b0;
            r_gid    <= '0;
        end else begin
            r_state  <= w_next;
            r_ptr    <= w_ptr;
            r_sh     <= w_sh;
            r_pcnt   <= w_pcnt;
            r_gcnt   <= w_gcnt;
            r_par1   <= w_par1;
            r_par2   <= w_par2;
            r_ser_en <= w_ser_en;
            r_gid    <= w_gid;
        end
    end

`ifdef CONV_SER_PARITY_EN
    // Even parity taken from the word as it is accepted
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_parity <= 1'b0;
        end else if (w_grant) begin
            r_parity <= ^w_sel_data;
        end
    end
`endif

    assign PAR_IN1  = r_par1;
    assign PAR_IN2  = r_par2;
    assign SER_EN   = r_ser_en;
    assign GRANT_ID = r_gid;
    assign BUSY     = (r_state != S_IDLE);

endmodule

// File: tb/tb_conv_serial_scheduler.sv
// Bench for conv_serial_scheduler: frame-level queue model plus directed cases.
// Honours CONV_SER_PARITY_EN when the build defines it.
module tb_conv_serial_scheduler;

    localparam int NREQ = 4;
    localparam int WIDTH = 16;
    localparam int GAPC = 2;
    localparam int HALF = WIDTH / 2;
`ifdef CONV_SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PERIOD  = 3 + HALF + P + GAPC;
    localparam int PERIOD0 = 3 + HALF + P;

    logic                  CLK;
    logic                  RESET;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  par1, par2, ser_en, busy;
    logic [1:0]            gid;

    logic [NREQ-1:0]       valid0;
    logic [NREQ*WIDTH-1:0] data0;
    logic [NREQ-1:0]       ready0;
    logic                  p10, p20, ser0, busy0;
    logic [1:0]            gid0;

    conv_serial_scheduler #(
        .NREQ(NREQ), .WIDTH(WIDTH), .GAP_CYCLES(GAPC)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(req_valid), .REQ_DATA(req_data),
        .REQ_READY(req_ready),
        .PAR_IN1(par1), .PAR_IN2(par2), .SER_EN(ser_en),
        .GRANT_ID(gid), .BUSY(busy)
    );

    conv_serial_scheduler #(
        .NREQ(NREQ), .WIDTH(WIDTH), .GAP_CYCLES(0)
    ) dut0 (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(valid0), .REQ_DATA(data0),
        .REQ_READY(ready0),
        .PAR_IN1(p10), .PAR_IN2(p20), .SER_EN(ser0),
        .GRANT_ID(gid0), .BUSY(busy0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame model: each granted word expands into a queue of per-cycle
    // {PAR_IN1, PAR_IN2, SER_EN, BUSY} expectations.
    logic [3:0]      q[$];
    int              m_ptr;
    logic [1:0]      m_gid;
    int              m_grant;
    logic [NREQ-1:0] exp_ready;
    logic            exp_p1, exp_p2, exp_ser, exp_busy;
    logic [1:0]      exp_gid;

    task automatic model_reset();
        q.delete();
        m_ptr = 0;
        m_gid = 2'd0;
    endtask

    task automatic model_cycle();
        logic [WIDTH-1:0] d;
        int idx;
        logic pb;
        exp_gid   = m_gid;
        exp_ready = '0;
        m_grant   = -1;
        if (q.size() > 0) begin
            {exp_p1, exp_p2, exp_ser, exp_busy} = q.pop_front();
        end else begin
            {exp_p1, exp_p2, exp_ser, exp_busy} = 4'b0000;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (m_grant < 0 && req_valid[idx]) m_grant = idx;
            end
            if (m_grant >= 0) begin
                exp_ready[m_grant] = 1'b1;
                m_ptr = (m_grant + 1) % NREQ;
                m_gid = 2'(m_grant);
                d = req_data[m_grant*WIDTH +: WIDTH];
                q.push_back(4'b1011);
                q.push_back({m_gid, 2'b11});
                for (int j = 0; j < HALF; j++)
                    q.push_back({d[WIDTH-1-2*j], d[WIDTH-2-2*j], 2'b11});
                if (P == 1) begin
                    pb = ^d;
                    q.push_back({pb, ~pb, 2'b11});
                end
                for (int g = 0; g < GAPC; g++) q.push_back(4'b0001);
            end
        end
    endtask

    task automatic new_data(input int i);
        req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        req_valid = '0;
        valid0 = '0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        req_valid = 4'hF;
        valid0 = 4'hF;
        req_data = {$urandom, $urandom};
        data0 = {$urandom, $urandom};
        @(negedge CLK);
        n_tests++;
        if ({req_ready, par1, par2, ser_en, busy, gid} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset got=%b exp=0",
                     {req_ready, par1, par2, ser_en, busy, gid});
        end
        n_tests++;
        if ({ready0, p10, p20, ser0, busy0, gid0} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_gap0 got=%b exp=0",
                     {ready0, p10, p20, ser0, busy0, gid0});
        end
        @(posedge CLK);
        #1;
        req_valid = '0;
        valid0 = '0;
        RESET = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        logic [1:0] tbl [10];
        tbl = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b01,
                2'b01, 2'b11, 2'b00, 2'b00, 2'b11};
        do_reset();
        req_valid = 4'b0010;
        req_data[1*WIDTH +: WIDTH] = 16'hA5C3;
        for (int c = 0; c <= PERIOD + 1; c++) begin
            @(negedge CLK);
            model_cycle();
            n_tests++;
            if ({req_ready, par1, par2, ser_en, busy, gid} !==
                {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid}) begin
                n_fail++;
                $display("FAIL single c=%0d got=%b exp=%b", c,
                    {req_ready, par1, par2, ser_en, busy, gid},
                    {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid});
            end
            if (c == 0) begin
                n_tests++;
                if (req_ready !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL single_ready got=%b exp=0010", req_ready);
                end
            end
            if (c >= 1 && c <= 10) begin
                n_tests++;
                if ({par1, par2} !== tbl[c-1]) begin
                    n_fail++;
                    $display("FAIL single_pair c=%0d got=%b exp=%b",
                             c, {par1, par2}, tbl[c-1]);
                end
            end
            if (c == PERIOD) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_busy got=%b exp=0", busy);
                end
            end
            @(posedge CLK);
            #1;
            if (c == 0) req_valid = '0;
        end
    endtask

    task automatic test_round_robin();
        int order[$];
        int at[$];
        int want[5];
        want = '{0, 1, 2, 3, 0};
        do_reset();
        req_valid = 4'hF;
        for (int c = 0; c <= 4 * PERIOD + 2; c++) begin
            @(negedge CLK);
            model_cycle();
            n_tests++;
            if ({req_ready, par1, par2, ser_en, busy, gid} !==
                {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid}) begin
                n_fail++;
                $display("FAIL rr c=%0d got=%b exp=%b", c,
                    {req_ready, par1, par2, ser_en, busy, gid},
                    {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid});
            end
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) begin
                    order.push_back(i);
                    at.push_back(c);
                end
            @(posedge CLK);
            #1;
            for (int i = 0; i < NREQ; i++)
                if (exp_ready[i]) new_data(i);
        end
        req_valid = '0;
        n_tests++;
        if (order.size() != 5) begin
            n_fail++;
            $display("FAIL rr_count got=%0d exp=5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_tests++;
                if (order[k] != want[k] || at[k] != k * PERIOD) begin
                    n_fail++;
                    $display("FAIL rr_grant k=%0d got=%0d@%0d exp=%0d@%0d",
                             k, order[k], at[k], want[k], k * PERIOD);
                end
            end
        end
    endtask

    task automatic test_ptr_skip();
        int order[$];
        do_reset();
        req_valid = 4'b0010;
        for (int c = 0; c < 3 * PERIOD + 2; c++) begin
            @(negedge CLK);
            model_cycle();
            n_tests++;
            if ({req_ready, par1, par2, ser_en, busy, gid} !==
                {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid}) begin
                n_fail++;
                $display("FAIL ptr c=%0d got=%b exp=%b", c,
                    {req_ready, par1, par2, ser_en, busy, gid},
                    {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid});
            end
            if (c > 0)
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i]) order.push_back(i);
            @(posedge CLK);
            #1;
            req_valid = req_valid & ~exp_ready;
            if (c == PERIOD - 1) begin
                req_valid = 4'b1001;
                new_data(0);
                new_data(3);
            end
        end
        n_tests++;
        if (order.size() != 2 || order[0] != 3 || order[1] != 0) begin
            n_fail++;
            $display("FAIL ptr_order got=%p exp=3,0", order);
        end
    endtask

    task automatic test_reset_mid();
        int first;
        first = -1;
        do_reset();
        req_valid = 4'b0001;
        new_data(0);
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            model_cycle();
            n_tests++;
            if ({req_ready, par1, par2, ser_en, busy, gid} !==
                {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid}) begin
                n_fail++;
                $display("FAIL rmid c=%0d got=%b exp=%b", c,
                    {req_ready, par1, par2, ser_en, busy, gid},
                    {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid});
            end
            @(posedge CLK);
            #1;
            req_valid = '0;
        end
        RESET = 1'b0;
        req_valid = 4'b0101;
        new_data(2);
        #1;
        n_tests++;
        if ({req_ready, par1, par2, ser_en, busy, gid} !== 10'd0) begin
            n_fail++;
            $display("FAIL rmid_async got=%b exp=0",
                     {req_ready, par1, par2, ser_en, busy, gid});
        end
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        model_reset();
        for (int c = 0; c < 2 * PERIOD + 2; c++) begin
            @(negedge CLK);
            model_cycle();
            n_tests++;
            if ({req_ready, par1, par2, ser_en, busy, gid} !==
                {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid}) begin
                n_fail++;
                $display("FAIL rmid_post c=%0d got=%b exp=%b", c,
                    {req_ready, par1, par2, ser_en, busy, gid},
                    {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid});
            end
            if (first < 0)
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i]) first = i;
            @(posedge CLK);
            #1;
            req_valid = req_valid & ~exp_ready;
        end
        n_tests++;
        if (first != 0) begin
            n_fail++;
            $display("FAIL rmid_first got=%0d exp=0", first);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            model_cycle();
            n_tests++;
            if ({req_ready, par1, par2, ser_en, busy, gid} !==
                {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid}) begin
                n_fail++;
                $display("FAIL random c=%0d got=%b exp=%b", c,
                    {req_ready, par1, par2, ser_en, busy, gid},
                    {exp_ready, exp_p1, exp_p2, exp_ser, exp_busy, exp_gid});
            end
            @(posedge CLK);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (exp_ready[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    new_data(i);
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req_valid[i] = 1'b1;
                        new_data(i);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
    endtask

    task automatic test_gap0();
        int last;
        int n;
        last = -1;
        n = 0;
        do_reset();
        valid0 = 4'b0100;
        data0[2*WIDTH +: WIDTH] = WIDTH'($urandom);
        for (int c = 0; c <= 3 * PERIOD0 + 1; c++) begin
            @(negedge CLK);
            n_tests++;
            if (ready0 != '0) begin
                n++;
                if (ready0 !== 4'b0100 || ser0 !== 1'b0 ||
                    (last >= 0 && c - last != PERIOD0)) begin
                    n_fail++;
                    $display("FAIL gap0_grant c=%0d got=%b/%0d exp=0100/%0d",
                             c, ready0, c - last, PERIOD0);
                end
                last = c;
            end else if (ser0 !== 1'b1 || busy0 !== 1'b1) begin
                n_fail++;
                $display("FAIL gap0_idle c=%0d got=%b%b exp=11",
                         c, ser0, busy0);
            end
            @(posedge CLK);
            #1;
            if (ready0[2]) data0[2*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        valid0 = '0;
        n_tests++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL gap0_count got=%0d exp=4", n);
        end
    endtask

    initial begin
        req_valid = '0;
        req_data = '0;
        valid0 = '0;
        data0 = '0;
        RESET = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_skip();
        test_reset_mid();
        test_random();
        test_gap0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_serial_scheduler.md
# conv_serial_scheduler

Round-robin scheduler that shares one 2:1 conv serializer lane among up to four requesters. It accepts parallel words through a valid/ready handshake and frames each word as START, ID and DATA bit-pairs, with optional PARITY, then a GAP. Each cycle it drives the serializer's PAR_IN1/PAR_IN2 pair. It sits directly upstream of the serializer in the conv tree and runs on the same CLK.

## Interface
- NREQ, 4: number of requesters, legal range 2..4.
- WIDTH, 16: data word width, even, ≥2.
- GAP_CYCLES, 2: idle cycles after each frame, legal range 0..15.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ_VALID  in  NREQ  per-requester word-valid.
- REQ_DATA  in  NREQ*WIDTH  requester i's word in bits [i*WIDTH +: WIDTH].
- REQ_READY  out  NREQ  one-hot acceptance strobe, combinational.
- PAR_IN1  out  1  first bit of the current pair, registered; feeds the serializer.
- PAR_IN2  out  1  second bit of the current pair, registered.
- SER_EN  out  1  high while a frame (START..last DATA/PARITY) is on PAR_IN*.
- GRANT_ID  out  2  requester index of the current or last frame, registered.
- BUSY  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE → START when any REQ_VALID is high.
  - START → ID → DATA.
  - DATA (WIDTH/2 cycles) → PARITY, if the parity feature is compiled in, else → GAP.
  - PARITY → GAP.
  - GAP (GAP_CYCLES cycles) → IDLE.
  - With GAP_CYCLES=0, GAP is skipped and the transition goes straight to IDLE.
- Arbitration runs in IDLE only. Round-robin from pointer PTR (reset 0):
  - Pick the first valid index among PTR, PTR+1, … mod NREQ.
  - On grant of index i, PTR ← (i+1) mod NREQ.
- REQ_READY[i] is high only in IDLE for the granted i. The word is captured into the shift register at that edge.
- Valid may be dropped before grant without penalty. Data must be stable while valid is high.
- Pair encoding (PAR_IN1, PAR_IN2):
  - START = (1,0).
  - ID = (id[1], id[0]).
  - DATA = MSB-first pairs: (d[W-1], d[W-2]), then (d[W-3], d[W-4]), …
  - IDLE and GAP = (0,0).
- Counters:
  - The pair counter counts down from WIDTH/2-1 and reloads on entry to DATA.
  - The gap counter is 4 bits.
- Reset values: PAR_IN1=0, PAR_IN2=0, SER_EN=0, BUSY=0, GRANT_ID=0, REQ_READY=0, PTR=0, state IDLE.
- Reset asserted mid-frame:
  - Outputs go to their reset values immediately (asynchronously) and the frame is abandoned.
  - No REQ_READY is issued for a reset-killed frame retroactively. The word was already consumed.
- Requests arriving in non-IDLE states wait. There is no preemption.

## Timing
- Cycle t (IDLE, valid seen): REQ_READY high; capture at the end of t.
- t+1: START on PAR_IN*, SER_EN=1, BUSY=1, GRANT_ID valid.
- t+2: ID.
- t+3 .. t+2+WIDTH/2: DATA.
- Parity enabled: PARITY at t+3+WIDTH/2.
- SER_EN falls on the first GAP or IDLE cycle.
- Frame period: 3 + WIDTH/2 + P + GAP_CYCLES cycles (P = 1 if parity enabled, else 0). The minimum single IDLE cycle between frames is included in this count.
- Defaults without parity: period 13. With GAP_CYCLES=0: period 11.

## Configuration
- CONV_SER_PARITY_EN defined:
  - A PARITY pair follows DATA: (p, ~p), where p = XOR of all data bits (even parity).
  - Period increases by one cycle.
- CONV_SER_PARITY_EN undefined: no PARITY state; DATA goes directly to GAP or IDLE.

## Test plan
- Single request, REQ_VALID[1]=1, REQ_DATA[1]=16'hA5C3, defaults, no parity:
  - REQ_READY=4'b0010 at t.
  - PAR_IN* sequence: (1,0) (0,1) (1,0)(1,0)(0,1)(0,1)(1,1)(0,0)(0,0)(1,1).
  - Then (0,0) for two GAP cycles.
  - BUSY falls at t+13.
- All four valid continuously: grants 0,1,2,3,0 in order, one grant per 13 cycles, GRANT_ID matching.
- PTR=2 with only requesters 0 and 3 valid: grant 3 first, then 0.
- Parity build, data 16'h0001: PARITY pair (1,0) at t+11; next REQ_READY at t+14.
- RESET low at t+5 (mid-DATA): all outputs 0 within the same cycle. After release, PTR=0, and requester 0 is granted before 2.
- GAP_CYCLES=0, requester 2 held valid: REQ_READY pulses every 11 cycles; no (0,0) GAP pairs beyond the single IDLE cycle.
